lcd1602_ctrl: RTL and testbench



---
 rtl/lcd1602_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lcd1602_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_ctrl.sv
// HD44780/LCD1602 write sequencer: power-up wait, fixed init ROM, then
// client command/data bytes with setup, EN pulse, hold and execution wait.
module lcd1602_ctrl #(
    parameter int T_POWERUP   = 750000,
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       ireq_valid,
    input  logic       ireq_rs,
    input  logic [7:0] ireq_data,
    output logic       oreq_ready,
    output logic       oinit_done,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);

    localparam int CNT_MAX = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LD_PWRUP = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN_HIGH - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          rdy_q, rdy_d;
    logic          done_q, done_d;

    logic cnt_zero;
    logic long_cmd;

    function automatic logic [7:0] init_rom(input logic [1:0] i);
        logic [7:0] b;
        unique case (i)
            2'd0: b = 8'h38;
            2'd1: b = 8'h0C;
            2'd2: b = 8'h01;
            2'd3: b = 8'h06;
        endcase
        return b;
    endfunction

    assign cnt_zero = (cnt_q == '0);
    assign long_cmd = !rs_q && (data_q[7:2] == 6'd0);

    // Init entries are loaded on the edge that leaves PWRUP/EXEC, so they
    // follow exactly the same per-write timing as client bytes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        done_d  = done_q;
        case (state_q)
            S_PWRUP: begin
                if (cnt_zero) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_rom(2'd0);
                end
            end
            S_IDLE: begin
                if (ireq_valid && rdy_q) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    rs_d    = ireq_rs;
                    data_d  = ireq_data;
                    rdy_d   = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_EN;
                    en_d    = 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                    en_d    = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_EXEC;
                    cnt_d   = long_cmd ? LD_LONG : LD_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_zero) begin
                    if (done_q || idx_q == 2'd3) begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        data_d  = init_rom(idx_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = LD_PWRUP;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= S_PWRUP;
            cnt_q   <= LD_PWRUP;
            idx_q   <= 2'd0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign oreq_ready = rdy_q;
    assign oinit_done = done_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_q;
    assign LCD_RS     = rs_q;
    assign LCD_DATA   = data_q;

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// Scoreboard bench for lcd1602_ctrl: expected writes queued at accept,
// popped and checked at every LCD_EN rising edge.
module tb_lcd1602_ctrl;

    localparam int T_POWERUP   = 20;
    localparam int T_SETUP     = 2;
    localparam int T_EN_HIGH   = 3;
    localparam int T_HOLD      = 1;
    localparam int T_EXEC      = 5;
    localparam int T_EXEC_LONG = 10;

    typedef struct packed {
        logic        rs;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    logic       iclk;
    logic       irst;
    logic       ireq_valid;
    logic       ireq_rs;
    logic [7:0] ireq_data;
    logic       oreq_ready;
    logic       oinit_done;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    logic [7:0] LCD_DATA;

    int total;
    int bad;
    int pushed;
    int pulses;

    logic [31:0] cyc;
    logic [31:0] rise_cyc;
    logic        en_prev;
    exp_t        sb[$];

    lcd1602_ctrl #(
        .T_POWERUP  (T_POWERUP),
        .T_SETUP    (T_SETUP),
        .T_EN_HIGH  (T_EN_HIGH),
        .T_HOLD     (T_HOLD),
        .T_EXEC     (T_EXEC),
        .T_EXEC_LONG(T_EXEC_LONG)
    ) dut (
        .iclk      (iclk),
        .irst      (irst),
        .ireq_valid(ireq_valid),
        .ireq_rs   (ireq_rs),
        .ireq_data (ireq_data),
        .oreq_ready(oreq_ready),
        .oinit_done(oinit_done),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .LCD_RS    (LCD_RS),
        .LCD_DATA  (LCD_DATA)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk or posedge irst) begin
        if (irst) cyc <= '0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int period(input logic rs, input logic [7:0] d);
        int ex;
        ex = (!rs && d < 8'h04) ? T_EXEC_LONG : T_EXEC;
        return T_SETUP + T_EN_HIGH + T_HOLD + ex;
    endfunction

    // EN monitor: check each pulse against the oldest expected write
    always @(negedge iclk) begin
        if (irst) begin
            en_prev <= 1'b0;
        end else begin
            if (LCD_EN && !en_prev) begin
                pulses   <= pulses + 1;
                rise_cyc <= cyc;
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                chk("rdy_at_en", 32'(oreq_ready), 0);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("en_rs_data", {LCD_RS, LCD_DATA}, {e.rs, e.data});
                    chk("en_rise_cyc", cyc, e.cyc);
                end
            end
            if (!LCD_EN && en_prev)
                chk("en_width", cyc - rise_cyc, T_EN_HIGH);
            en_prev <= LCD_EN;
        end
    end

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (oreq_ready !== 1'b1 && n < 400) begin
            @(negedge iclk);
            n++;
        end
        chk(tag, 32'(oreq_ready), 1);
    endtask

    task automatic init_seq();
        logic [7:0]  rom [4];
        logic [31:0] e0;
        rom = '{8'h38, 8'h0C, 8'h01, 8'h06};
        e0  = T_POWERUP;
        irst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_t'{1'b0, rom[i], e0 + T_SETUP});
            pushed++;
            e0 += period(1'b0, rom[i]);
        end
        wait_ready("init_wait");
        chk("init_rdy_cyc", cyc, e0);
        chk("init_done", 32'(oinit_done), 1);
        chk("init_last", {LCD_RS, LCD_DATA}, {1'b0, 8'h06});
    endtask

    // mode 0: drop valid after accept; 1: keep valid (back-to-back);
    // 2: keep valid with other data until ready returns
    task automatic send(input logic rs, input logic [7:0] d, input int mode,
                        output logic [31:0] e0);
        ireq_valid = 1'b1;
        ireq_rs    = rs;
        ireq_data  = d;
        wait_ready("acc_wait");
        @(posedge iclk);
        #1;
        e0 = cyc;
        sb.push_back(exp_t'{rs, d, e0 + T_SETUP});
        pushed++;
        chk("acc_rdy_drop", 32'(oreq_ready), 0);
        chk("acc_data", {LCD_RS, LCD_DATA}, {rs, d});
        if (mode == 0) ireq_valid = 1'b0;
        else if (mode == 2) ireq_data = ~d;
        @(negedge iclk);
        wait_ready("exec_wait");
        chk("rdy_cyc", cyc, e0 + period(rs, d));
        chk("hold_data", {LCD_RS, LCD_DATA}, {rs, d});
        if (mode == 2) ireq_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] e0, e1, e2;
        int n;
        total = 0; bad = 0; pushed = 0; pulses = 0;
        en_prev = 1'b0; rise_cyc = '0;
        irst = 1'b1;
        ireq_valid = 1'b0; ireq_rs = 1'b0; ireq_data = 8'h00;
        repeat (3) @(negedge iclk);
        chk("rst_en", 32'(LCD_EN), 0);
        chk("rst_rs", 32'(LCD_RS), 0);
        chk("rst_data", 32'(LCD_DATA), 0);
        chk("rst_rw", 32'(LCD_RW), 0);
        chk("rst_rdy", 32'(oreq_ready), 0);
        chk("rst_done", 32'(oinit_done), 0);

        // request held during init must be ignored
        ireq_valid = 1'b1; ireq_rs = 1'b1; ireq_data = 8'h5A;
        init_seq();
        ireq_valid = 1'b0;
        repeat (2) @(negedge iclk);

        send(1'b1, 8'h41, 2, e0);
        repeat (3) @(negedge iclk);

        send(1'b0, 8'h01, 0, e0);
        send(1'b0, 8'h02, 0, e0);
        send(1'b1, 8'h01, 0, e0);
        send(1'b0, 8'h03, 0, e0);
        send(1'b0, 8'h04, 0, e0);
        repeat (2) @(negedge iclk);

        send(1'b1, 8'h48, 1, e0);
        send(1'b1, 8'h49, 1, e1);
        send(1'b1, 8'h21, 0, e2);
        chk("b2b_gap1", e1 - e0, period(1'b1, 8'h48) + 1);
        chk("b2b_gap2", e2 - e1, period(1'b1, 8'h49) + 1);
        repeat (2) @(negedge iclk);

        // reset in the middle of an EN pulse
        ireq_valid = 1'b1; ireq_rs = 1'b1; ireq_data = 8'h7E;
        wait_ready("rst_acc_wait");
        @(posedge iclk);
        #1;
        sb.push_back(exp_t'{1'b1, 8'h7E, cyc + T_SETUP});
        pushed++;
        ireq_valid = 1'b0;
        n = 0;
        while (LCD_EN !== 1'b1 && n < 50) begin
            @(negedge iclk);
            n++;
        end
        chk("mid_en_seen", 32'(LCD_EN), 1);
        #3;
        irst = 1'b1;
        #1;
        chk("mid_rst_en", 32'(LCD_EN), 0);
        chk("mid_rst_data", 32'(LCD_DATA), 0);
        chk("mid_rst_done", 32'(oinit_done), 0);
        chk("mid_rst_rdy", 32'(oreq_ready), 0);
        repeat (3) @(negedge iclk);
        init_seq();
        repeat (5) @(negedge iclk);

        chk("sb_left", sb.size(), 0);
        chk("pulse_count", pulses, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
